// File: rtl/btn_select_ctrl_if.sv
// Button/selection bundle between board push-buttons and their consumers.
// master drives raw levels and the lock; slave returns conditioned levels, pulses and the selection.
`timescale 1ns/1ps
interface btn_select_ctrl_if #(
  parameter int NUM_BTNS  = 5,
  parameter int SEL_WIDTH = 32
);
  logic [NUM_BTNS-1:0]  btn_raw;
  logic                 sel_lock;
  logic [NUM_BTNS-1:0]  btn_level;
  logic [NUM_BTNS-1:0]  btn_press;
  logic [NUM_BTNS-1:0]  btn_release;
  logic [SEL_WIDTH-1:0] sel_value;
  logic                 sel_changed;

  modport master (
    output btn_raw,
    output sel_lock,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  sel_value,
    input  sel_changed
  );

  modport slave (
    input  btn_raw,
    input  sel_lock,
    output btn_level,
    output btn_press,
    output btn_release,
    output sel_value,
    output sel_changed
  );
endinterface

// File: rtl/btn_select_ctrl.sv
// Push-button conditioner (sync, debounce, press/release/repeat pulses) plus lockable selection register.
// Pulses appear DEBOUNCE_CYCLES+2 edges after a steady raw change; selection follows one edge later.
`timescale 1ns/1ps
module btn_select_ctrl #(
  parameter int                   NUM_BTNS        = 5,
  parameter int                   DEBOUNCE_CYCLES = 500000,
  parameter int                   REPEAT_CYCLES   = 0,
  parameter int                   SEL_WIDTH       = 32,
  parameter logic [SEL_WIDTH-1:0] SEL_BASE        = SEL_WIDTH'(1),
  parameter logic [SEL_WIDTH-1:0] SEL_RESET       = SEL_WIDTH'(0),
  parameter logic [NUM_BTNS-1:0]  SEL_MASK        = {NUM_BTNS{1'b1}}
) (
  input logic              clock,
  input logic              anti_reset,
  btn_select_ctrl_if.slave bus
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int              RP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = (REPEAT_CYCLES > 0) ? RP_W'(REPEAT_CYCLES - 1) : '0;
  localparam bit              RP_EN   = (REPEAT_CYCLES > 0);

  logic [NUM_BTNS-1:0]  sync_s1;
  logic [NUM_BTNS-1:0]  sync_s2;
  logic [NUM_BTNS-1:0]  level_vec;
  logic [NUM_BTNS-1:0]  press_vec;
  logic [NUM_BTNS-1:0]  release_vec;
  logic [SEL_WIDTH-1:0] sel_q;
  logic                 sel_changed_q;
  logic                 cand_vld;
  logic [SEL_WIDTH-1:0] cand_val;

  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= bus.btn_raw;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rp_cnt;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            differ;
    logic            accept;
    logic            rp_hit;

    assign differ = sync_s2[g] ^ level_q;
    assign accept = differ && (db_cnt == DB_LAST);
    assign rp_hit = RP_EN && (rp_cnt == RP_LAST);

    always_ff @(posedge clock or negedge anti_reset) begin
      if (!anti_reset) begin
        db_cnt    <= '0;
        rp_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;

        if (!differ) begin
          db_cnt <= '0;
        end else if (accept) begin
          level_q   <= sync_s2[g];
          db_cnt    <= '0;
          press_q   <= sync_s2[g];
          release_q <= ~sync_s2[g];
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        // While held, accept can only be a release, which must also kill the repeat phase.
        if (!level_q || accept) begin
          rp_cnt <= '0;
        end else if (rp_hit) begin
          rp_cnt  <= '0;
          press_q <= 1'b1;
        end else if (RP_EN) begin
          rp_cnt <= rp_cnt + 1'b1;
        end
      end
    end

    assign level_vec[g]   = level_q;
    assign press_vec[g]   = press_q;
    assign release_vec[g] = release_q;
  end

  // Descending scan so the lowest-index eligible press ends up as the candidate.
  always_comb begin
    cand_vld = 1'b0;
    cand_val = SEL_BASE;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (press_vec[i] && SEL_MASK[i]) begin
        cand_vld = 1'b1;
        cand_val = SEL_BASE + SEL_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      sel_q         <= SEL_RESET;
      sel_changed_q <= 1'b0;
    end else begin
      sel_changed_q <= 1'b0;
      if (cand_vld && !bus.sel_lock) begin
        sel_q         <= cand_val;
        sel_changed_q <= (cand_val != sel_q);
      end
    end
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;
  assign bus.sel_value   = sel_q;
  assign bus.sel_changed = sel_changed_q;

endmodule

// File: tb/tb_btn_select_ctrl.sv
// Bench for btn_select_ctrl: two instances (no repeat / repeat=8 with a channel mask) share stimulus
// and are compared every cycle against a cycle-level behavioural model, plus directed scenario checks.
`timescale 1ns/1ps
module tb_btn_select_ctrl;

  localparam int NB       = 5;
  localparam int DEB      = 4;
  localparam int REP_A    = 0;
  localparam int REP_B    = 8;
  localparam logic [4:0] MASK_A = 5'b11111;
  localparam logic [4:0] MASK_B = 5'b10111;
  localparam logic [31:0] BASE  = 32'd1;
  localparam logic [31:0] RST_V = 32'd0;

  logic       clock;
  logic       rst_n;
  logic [4:0] raw_drv;
  logic       lock_drv;

  int n_chk;
  int n_fail;

  logic [4:0] acc_press_a;
  int         n_press_a0;
  int         n_press_b0;
  int         n_chg_a;
  int         n_chg_b;

  // model state, index 0 = instance a, 1 = instance b
  logic [4:0]  m_s1  [2];
  logic [4:0]  m_s2  [2];
  logic [4:0]  m_lvl [2];
  logic [4:0]  m_prs [2];
  logic [4:0]  m_rel [2];
  logic [31:0] m_sel [2];
  logic        m_chg [2];
  int          m_run [2][5];
  int          m_age [2][5];

  btn_select_ctrl_if #(.NUM_BTNS(NB), .SEL_WIDTH(32)) bus_a ();
  btn_select_ctrl_if #(.NUM_BTNS(NB), .SEL_WIDTH(32)) bus_b ();

  assign bus_a.btn_raw  = raw_drv;
  assign bus_a.sel_lock = lock_drv;
  assign bus_b.btn_raw  = raw_drv;
  assign bus_b.sel_lock = lock_drv;

  btn_select_ctrl #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP_A), .SEL_WIDTH(32),
    .SEL_BASE(BASE), .SEL_RESET(RST_V), .SEL_MASK(MASK_A)
  ) dut_a (
    .clock(clock), .anti_reset(rst_n), .bus(bus_a.slave)
  );

  btn_select_ctrl #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP_B), .SEL_WIDTH(32),
    .SEL_BASE(BASE), .SEL_RESET(RST_V), .SEL_MASK(MASK_B)
  ) dut_b (
    .clock(clock), .anti_reset(rst_n), .bus(bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_lvl[k] = '0; m_prs[k] = '0; m_rel[k] = '0;
      m_sel[k] = RST_V; m_chg[k] = 1'b0;
      for (int i = 0; i < NB; i++) begin
        m_run[k][i] = 0;
        m_age[k][i] = 0;
      end
    end
  endtask

  // One clock edge: a level is accepted after DEB consecutive disagreeing synced samples;
  // a held level repeats every rep cycles of hold time; selection reacts to last edge's pulses.
  task automatic model_step(input logic [4:0] r, input logic lk);
    logic [4:0]  np, nr, nl, mask;
    int          win, rep;
    logic [31:0] nv;
    for (int k = 0; k < 2; k++) begin
      rep  = (k == 0) ? REP_A : REP_B;
      mask = (k == 0) ? MASK_A : MASK_B;
      win  = -1;
      for (int i = 0; i < NB; i++)
        if (win < 0 && m_prs[k][i] && mask[i]) win = i;
      m_chg[k] = 1'b0;
      if (win >= 0 && !lk) begin
        nv       = BASE + 32'(win);
        m_chg[k] = (nv != m_sel[k]);
        m_sel[k] = nv;
      end
      np = '0; nr = '0; nl = m_lvl[k];
      for (int i = 0; i < NB; i++) begin
        if (m_s2[k][i] == m_lvl[k][i]) begin
          m_run[k][i] = 0;
        end else begin
          m_run[k][i]++;
          if (m_run[k][i] == DEB) begin
            nl[i] = m_s2[k][i];
            m_run[k][i] = 0;
            if (nl[i]) np[i] = 1'b1; else nr[i] = 1'b1;
          end
        end
        if (m_lvl[k][i] && !nr[i]) begin
          m_age[k][i]++;
          if (rep > 0) begin
            if (m_age[k][i] % rep == 0) np[i] = 1'b1;
          end
        end else if (np[i]) begin
          m_age[k][i] = 0;
        end
      end
      m_lvl[k] = nl; m_prs[k] = np; m_rel[k] = nr;
      m_s2[k]  = m_s1[k];
      m_s1[k]  = r;
    end
  endtask

  task automatic compare_all();
    chk_eq("a_level",   32'(bus_a.btn_level),   32'(m_lvl[0]));
    chk_eq("a_press",   32'(bus_a.btn_press),   32'(m_prs[0]));
    chk_eq("a_release", 32'(bus_a.btn_release), 32'(m_rel[0]));
    chk_eq("a_sel",     bus_a.sel_value,        m_sel[0]);
    chk_eq("a_changed", 32'(bus_a.sel_changed), 32'(m_chg[0]));
    chk_eq("b_level",   32'(bus_b.btn_level),   32'(m_lvl[1]));
    chk_eq("b_press",   32'(bus_b.btn_press),   32'(m_prs[1]));
    chk_eq("b_release", 32'(bus_b.btn_release), 32'(m_rel[1]));
    chk_eq("b_sel",     bus_b.sel_value,        m_sel[1]);
    chk_eq("b_changed", 32'(bus_b.sel_changed), 32'(m_chg[1]));
  endtask

  task automatic clear_acc();
    acc_press_a = '0; n_press_a0 = 0; n_press_b0 = 0; n_chg_a = 0; n_chg_b = 0;
  endtask

  task automatic cycle(input logic [4:0] r, input logic lk);
    raw_drv  = r;
    lock_drv = lk;
    @(posedge clock);
    if (!rst_n) model_reset();
    else        model_step(r, lk);
    @(negedge clock);
    compare_all();
    acc_press_a = acc_press_a | bus_a.btn_press;
    if (bus_a.btn_press[0]) n_press_a0++;
    if (bus_b.btn_press[0]) n_press_b0++;
    if (bus_a.sel_changed)  n_chg_a++;
    if (bus_b.sel_changed)  n_chg_b++;
  endtask

  task automatic run_n(input logic [4:0] r, input logic lk, input int n);
    for (int c = 0; c < n; c++) cycle(r, lk);
  endtask

  initial begin
    logic [4:0] tgt;
    logic [4:0] rr;
    logic       lk;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; raw_drv = '0; lock_drv = 1'b0;
    model_reset();
    clear_acc();
    @(negedge clock);
    @(negedge clock);
    chk_eq("rst_level", 32'(bus_a.btn_level), 32'd0);
    chk_eq("rst_press", 32'(bus_a.btn_press), 32'd0);
    chk_eq("rst_sel",   bus_a.sel_value,      32'd0);
    chk_eq("rst_chg",   32'(bus_b.sel_changed), 32'd0);
    rst_n = 1'b1;
    run_n(5'b00000, 1'b0, 3);

    // short glitch on channel 0 is swallowed
    clear_acc();
    run_n(5'b00001, 1'b0, 3);
    run_n(5'b00000, 1'b0, 8);
    chk_eq("glitch_press", 32'(acc_press_a),     32'd0);
    chk_eq("glitch_level", 32'(bus_a.btn_level), 32'd0);
    chk_eq("glitch_sel",   bus_a.sel_value,      32'd0);

    // valid press then release: release pulse exactly 6 edges after the fall
    run_n(5'b00001, 1'b0, 10);
    chk_eq("ch0_sel", bus_a.sel_value, 32'd1);
    run_n(5'b00000, 1'b0, 5);
    chk_eq("rel_e5", 32'(bus_a.btn_release), 32'd0);
    run_n(5'b00000, 1'b0, 1);
    chk_eq("rel_e6", 32'(bus_a.btn_release), 32'b00001);
    run_n(5'b00000, 1'b0, 4);

    // channel 2 press latency
    run_n(5'b00100, 1'b0, 5);
    chk_eq("p2_e5_press", 32'(bus_a.btn_press), 32'd0);
    run_n(5'b00100, 1'b0, 1);
    chk_eq("p2_e6_press", 32'(bus_a.btn_press), 32'b00100);
    chk_eq("p2_e6_level", 32'(bus_a.btn_level), 32'b00100);
    run_n(5'b00100, 1'b0, 1);
    chk_eq("p2_e7_sel",   bus_a.sel_value,        32'd3);
    chk_eq("p2_e7_chg",   32'(bus_a.sel_changed), 32'd1);
    chk_eq("p2_e7_press", 32'(bus_a.btn_press),   32'd0);
    run_n(5'b00000, 1'b0, 10);

    // simultaneous presses: lowest index wins
    run_n(5'b01010, 1'b0, 6);
    chk_eq("sim_press", 32'(bus_a.btn_press), 32'b01010);
    run_n(5'b01010, 1'b0, 1);
    chk_eq("sim_sel_a", bus_a.sel_value, 32'd2);
    chk_eq("sim_sel_b", bus_b.sel_value, 32'd2);
    run_n(5'b00000, 1'b0, 10);

    // lock freezes selection; press is not applied when lock drops
    clear_acc();
    run_n(5'b10000, 1'b1, 8);
    chk_eq("lock_press", 32'(acc_press_a), 32'b10000);
    chk_eq("lock_sel",   bus_a.sel_value,  32'd2);
    chk_eq("lock_chg",   32'(n_chg_a),     32'd0);
    run_n(5'b10000, 1'b0, 3);
    chk_eq("unlock_sel", bus_a.sel_value,  32'd2);
    chk_eq("unlock_chg", 32'(n_chg_a),     32'd0);
    run_n(5'b00000, 1'b0, 10);

    // masked channel 3 moves instance a only
    clear_acc();
    run_n(5'b01000, 1'b0, 7);
    chk_eq("mask_sel_a", bus_a.sel_value, 32'd4);
    chk_eq("mask_chg_b", 32'(n_chg_b),    32'd0);
    run_n(5'b00000, 1'b0, 10);

    // auto-repeat on instance b: pulses at acceptance, +8, +16, +24
    clear_acc();
    run_n(5'b00001, 1'b0, 36);
    chk_eq("rep_press_b", 32'(n_press_b0), 32'd4);
    chk_eq("rep_chg_b",   32'(n_chg_b),    32'd1);
    chk_eq("rep_press_a", 32'(n_press_a0), 32'd1);
    chk_eq("rep_sel_b",   bus_b.sel_value, 32'd1);
    run_n(5'b00000, 1'b0, 10);

    // reset mid-count while channel 2 is held
    run_n(5'b00100, 1'b0, 2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_eq("mid_rst_sel",   bus_a.sel_value,      32'd0);
    chk_eq("mid_rst_level", 32'(bus_a.btn_level), 32'd0);
    chk_eq("mid_rst_sel_b", bus_b.sel_value,      32'd0);
    run_n(5'b00100, 1'b0, 2);
    rst_n = 1'b1;
    run_n(5'b00100, 1'b0, 5);
    chk_eq("post_rst_e5", 32'(bus_a.btn_press), 32'd0);
    run_n(5'b00100, 1'b0, 1);
    chk_eq("post_rst_e6_a", 32'(bus_a.btn_press), 32'b00100);
    chk_eq("post_rst_e6_b", 32'(bus_b.btn_press), 32'b00100);
    run_n(5'b00000, 1'b0, 10);

    // random phase: slow level changes, single-cycle glitches, lock toggles, rare resets
    tgt = '0;
    lk  = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(11) == 0) tgt[i] = ~tgt[i];
      rr = tgt;
      if ($urandom_range(19) == 0) rr[$urandom_range(4)] = ~rr[$urandom_range(4)];
      if ($urandom_range(29) == 0) lk = ~lk;
      if (rst_n && $urandom_range(299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
      end else if (!rst_n && $urandom_range(1) == 0) begin
        rst_n = 1'b1;
      end
      cycle(rr, lk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_select_ctrl.md
Name: btn_select_ctrl

Overview:
- Parametrised successor to the hard-coded three-button difficulty register in the top-level wrapper.
- Conditions NUM_BTNS raw push-buttons: 2-flop synchronisation, per-channel debounce, press/release pulses, optional auto-repeat.
- Maintains a selection register (pressed channel index + SEL_BASE) with a lock input, so the game CPU can freeze the selection during play.
- Sits between board buttons and the processor's difficulty input; also feeds the VGA controller and other consumers with clean pulses.

Parameters:
- NUM_BTNS, 5, number of button channels (1..16).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- REPEAT_CYCLES, 0, auto-repeat period while held; 0 disables repeat.
- SEL_WIDTH, 32, width of the selection output.
- SEL_BASE, 1, value encoded for channel 0; channel i encodes SEL_BASE+i.
- SEL_RESET, 0, selection value after reset.
- SEL_MASK, all ones (NUM_BTNS bits), channels allowed to change the selection.

Ports:
- clock, in, 1, system clock (50 MHz).
- anti_reset, in, 1, asynchronous active-low reset.
- btn_raw, in, NUM_BTNS, raw asynchronous button levels, active-high.
- sel_lock, in, 1, when high the selection register holds its value.
- btn_level, out, NUM_BTNS, debounced button levels.
- btn_press, out, NUM_BTNS, one-cycle pulse per accepted press or auto-repeat.
- btn_release, out, NUM_BTNS, one-cycle pulse per accepted release.
- sel_value, out, SEL_WIDTH, current selection.
- sel_changed, out, 1, one-cycle pulse when sel_value takes a different value.

Behaviour:
- Reset (anti_reset low, asynchronous): sync flops, debounce counters and repeat counters = 0; btn_level = 0; btn_press = 0; btn_release = 0; sel_value = SEL_RESET; sel_changed = 0. Deassertion takes effect at the next clock edge.
- Sync: each channel passes through 2 flops (s1, s2). Only s2 is used downstream.
- Debounce, per channel:
  - If s2 == btn_level, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - On the edge where counter == DEBOUNCE_CYCLES-1 and s2 still differs: btn_level <= s2, counter <= 0, and btn_press (0->1) or btn_release (1->0) is registered high for exactly that cycle.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no pulse.
  - Latency: a steady raw change first sampled at edge 1 appears on btn_level and the pulse at edge DEBOUNCE_CYCLES+2.
- Auto-repeat (REPEAT_CYCLES > 0), per channel:
  - The repeat counter runs while btn_level == 1 and clears when btn_level == 0.
  - Each time it reaches REPEAT_CYCLES-1, btn_press pulses again and the counter wraps to 0.
  - The first repeat pulse occurs REPEAT_CYCLES cycles after the initial press pulse.
  - Release clears the counter on the same edge as the release pulse.
- Selection, registered one cycle after btn_press:
  - Candidate = lowest-index channel i with btn_press[i] && SEL_MASK[i].
  - If a candidate exists and sel_lock == 0: sel_value <= SEL_BASE+i.
  - sel_changed is high in the cycle the new value first appears, only if the new value differs from the old one. Re-pressing the current selection gives no sel_changed.
  - Simultaneous presses: lowest index wins; higher-index pulses in that cycle are discarded, not queued.
  - sel_lock high: presses are ignored for selection (pulses still emitted). A press during lock is not applied when lock later drops.
  - Auto-repeat pulses also drive selection; they are idempotent.
- Widths: SEL_BASE+i is computed in SEL_WIDTH bits and wraps modulo 2^SEL_WIDTH. Counter widths use $clog2 of the respective parameter (minimum 1).
- Reset mid-debounce or mid-repeat: all progress is lost; no pulse is emitted on exit from reset, even if a button is held. A held button is accepted DEBOUNCE_CYCLES+2 edges after reset release, as a fresh press.

Test Plan:
(Parameters DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0, SEL_BASE=1 unless stated.)
- btn_raw[2] rises and is held -> btn_level[2] and a one-cycle btn_press[2] at edge 6; sel_value=3 and sel_changed=1 at edge 7.
- btn_raw[0] high for 3 cycles then low -> no btn_level change, no pulses, sel_value stays 0; then a release after a valid press -> btn_release[0] exactly 6 edges after the fall.
- btn_raw[1] and btn_raw[3] rise on the same cycle -> both press pulses; sel_value=2, not 4.
- sel_value=2, sel_lock=1, press channel 4 -> btn_press[4] pulses, sel_value stays 2, sel_changed=0; drop lock -> still 2.
- REPEAT_CYCLES=8, hold channel 0 for 30 cycles after acceptance -> press pulses at acceptance and at +8, +16, +24; sel_changed only on the first.
- Hold btn_raw[2] through a reset pulse issued mid-count -> all outputs return to reset values immediately; btn_press[2] at edge 6 after reset release.
